wb_regfile: RTL and testbench
=============================

Name: wb_regfile

Overview:
- Write-back stage and general-register file for the 16-bit five-stage pipeline.
- Captures the MEM-stage instruction and result into the WB latches (wb_ir, reg_C1) and commits the result to gr0..gr7 one cycle later.
- Its outputs are exactly the wb_ir/reg_C1/gr0..gr7 values the decode stage reads and forwards from.
- Also tracks retirement and HALT.

Parameters:
- RETIRE_W, 16, width of retired-instruction counter (wraps).

Ports:
- clock  in  1  pipeline clock, rising edge
- reset  in  1  asynchronous, active-low; clears all state
- state  in  1  CPU run state; pipeline advances only when state == `exec
- mem_ir  in  16  instruction in MEM stage
- reg_C  in  16  ALU result latched in MEM stage
- d_datain  in  16  data-memory read data for MEM-stage LOAD
- wb_ir  out  16  instruction in WB stage
- reg_C1  out  16  WB-stage result (forwarding source)
- gr0..gr7  out  16 each  architectural registers
- retire_cnt  out  RETIRE_W  count of retired non-NOP instructions
- halted  out  1  HALT has retired; pipeline writes frozen

Behaviour:
- Reset (reset == 0, asynchronous): wb_ir, reg_C1, gr0..gr7 and retire_cnt all 0; halted = 0. Takes effect immediately, including mid-operation.
- Writer set W = {`LOAD, `LDIH, `ADD, `ADDI, `ADDC, `SUB, `SUBI, `SUBC, `AND, `OR, `XOR, `SLL, `SRL, `SLA, `SRA}. Opcode = ir[15:11]; destination = ir[10:8].
- Every rising edge with state == `exec and halted == 0, all updates below happen in parallel using pre-edge values:
  - Commit: if wb_ir[15:11] ∈ W, then gr[wb_ir[10:8]] <= reg_C1. No other register changes.
  - Latch: wb_ir <= mem_ir.
  - Result select: reg_C1 <= d_datain if mem_ir[15:11] == `LOAD, else reg_C. reg_C1 is latched for every opcode, including non-writers.
  - Retire: if wb_ir != 16'h0000, retire_cnt <= retire_cnt + 1 (modulo 2^RETIRE_W; all-ones wraps to 0).
  - Halt: if wb_ir[15:11] == `HALT, halted <= 1. The HALT itself counts as retired on that edge.
- Latency: a writer in MEM at edge N appears on wb_ir/reg_C1 after N and in gr after edge N+1. Between those edges the decode stage must forward from reg_C1; its priority order (EX > MEM > WB > gr) relies on this timing.
- state != `exec: all outputs hold.
- halted == 1: all outputs hold until reset, regardless of state. The HALT-retiring edge is the last edge on which commit and latch occur.
- Flushed and bubble instructions (all-zero ir) write nothing and are not counted.
- Non-writers (STORE, CMP, branches, JUMP, JMPR, NOP, HALT) never modify gr.
- Same-register back-to-back writes: the later instruction's value overwrites on the following edge; no merging.
- gr outputs are direct register outputs; no combinational path from inputs to gr0..gr7.

Optional Feature:
- Macro REGFILE_ZERO_GR0_EN.
- Defined: gr0 is constant 0; commits with destination 0 are dropped (still retired and counted). reg_C1 still carries the computed value.
- Undefined: gr0 is an ordinary writable register, identical to gr1..gr7.

Test Plan:
- Reset, then state = `exec, mem_ir = ADD r3 (dest 3), reg_C = 16'h1234, then mem_ir = 0 -> after edge 1: wb_ir = ADD r3, reg_C1 = 16'h1234; after edge 2: gr3 = 16'h1234, retire_cnt = 1.
- mem_ir = LOAD r5, d_datain = 16'hBEEF, reg_C = 16'h0007 -> reg_C1 = 16'hBEEF, then gr5 = 16'hBEEF; reg_C ignored.
- STORE r2 then CMP r1 through WB with reg_C = 16'hFFFF -> gr unchanged, retire_cnt += 2.
- Writer in WB with state = `idle for 3 edges -> gr, wb_ir and retire_cnt unchanged; commit occurs on the first `exec edge.
- HALT followed by ADDI r1 in MEM -> after HALT retires: halted = 1, gr1 never written, outputs frozen. Pull reset low asynchronously mid-cycle -> all outputs 0 immediately.
- With REGFILE_ZERO_GR0_EN: ADDI r0, reg_C = 16'h00AA -> gr0 stays 0, reg_C1 = 16'h00AA, retire_cnt increments. Without the macro: gr0 = 16'h00AA.

Source files
------------

// File: rtl/wb_regfile.sv
// Write-back latches and general-register file for the 16-bit five-stage pipeline.
// Optional build macro REGFILE_ZERO_GR0_EN hard-wires gr0 to zero.

`ifndef EXEC
`define EXEC  1'b1
`endif
`ifndef IDLE
`define IDLE  1'b0
`endif
`ifndef NOP
`define NOP   5'b00000
`endif
`ifndef HALT
`define HALT  5'b00001
`endif
`ifndef LOAD
`define LOAD  5'b00010
`endif
`ifndef STORE
`define STORE 5'b00011
`endif
`ifndef SLL
`define SLL   5'b00100
`endif
`ifndef SLA
`define SLA   5'b00101
`endif
`ifndef SRL
`define SRL   5'b00110
`endif
`ifndef SRA
`define SRA   5'b00111
`endif
`ifndef ADD
`define ADD   5'b01000
`endif
`ifndef ADDI
`define ADDI  5'b01001
`endif
`ifndef SUB
`define SUB   5'b01010
`endif
`ifndef SUBI
`define SUBI  5'b01011
`endif
`ifndef CMP
`define CMP   5'b01100
`endif
`ifndef AND
`define AND   5'b01101
`endif
`ifndef OR
`define OR    5'b01110
`endif
`ifndef XOR
`define XOR   5'b01111
`endif
`ifndef LDIH
`define LDIH  5'b10000
`endif
`ifndef ADDC
`define ADDC  5'b10001
`endif
`ifndef SUBC
`define SUBC  5'b10010
`endif

module wb_regfile #(
  parameter int RETIRE_W = 16
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                state,
  input  logic [15:0]         mem_ir,
  input  logic [15:0]         reg_C,
  input  logic [15:0]         d_datain,
  output logic [15:0]         wb_ir,
  output logic [15:0]         reg_C1,
  output logic [15:0]         gr0,
  output logic [15:0]         gr1,
  output logic [15:0]         gr2,
  output logic [15:0]         gr3,
  output logic [15:0]         gr4,
  output logic [15:0]         gr5,
  output logic [15:0]         gr6,
  output logic [15:0]         gr7,
  output logic [RETIRE_W-1:0] retire_cnt,
  output logic                halted
);

  logic [15:0]         wb_ir_q, wb_ir_d;
  logic [15:0]         reg_c1_q, reg_c1_d;
  logic [15:0]         gr_q [0:7];
  logic [15:0]         gr_d [0:7];
  logic [RETIRE_W-1:0] retire_cnt_q, retire_cnt_d;
  logic                halted_q, halted_d;
  logic                advance_s;
  logic                commit_s;

  function automatic logic is_writer(input logic [4:0] op);
    case (op)
      `LOAD, `LDIH, `ADD, `ADDI, `ADDC, `SUB, `SUBI, `SUBC,
      `AND, `OR, `XOR, `SLL, `SRL, `SLA, `SRA: is_writer = 1'b1;
      default:                                  is_writer = 1'b0;
    endcase
  endfunction

  assign advance_s = (state == `EXEC) && !halted_q;

  // Commits to gr use the WB latches as they stood before this edge.
`ifdef REGFILE_ZERO_GR0_EN
  assign commit_s = advance_s && is_writer(wb_ir_q[15:11]) && (wb_ir_q[10:8] != 3'd0);
`else
  assign commit_s = advance_s && is_writer(wb_ir_q[15:11]);
`endif

  // Next-state for WB latches, register file, retirement count and halt flag.
  always_comb begin
    wb_ir_d      = wb_ir_q;
    reg_c1_d     = reg_c1_q;
    retire_cnt_d = retire_cnt_q;
    halted_d     = halted_q;
    for (int i = 0; i < 8; i++) begin
      if (commit_s && (wb_ir_q[10:8] == 3'(i))) begin
        gr_d[i] = reg_c1_q;
      end else begin
        gr_d[i] = gr_q[i];
      end
    end
    if (advance_s) begin
      wb_ir_d  = mem_ir;
      reg_c1_d = (mem_ir[15:11] == `LOAD) ? d_datain : reg_C;
      if (wb_ir_q != 16'h0000) begin
        retire_cnt_d = retire_cnt_q + RETIRE_W'(1);
      end else begin
        retire_cnt_d = retire_cnt_q;
      end
      if (wb_ir_q[15:11] == `HALT) begin
        halted_d = 1'b1;
      end else begin
        halted_d = halted_q;
      end
    end else begin
      wb_ir_d = wb_ir_q;
    end
`ifdef REGFILE_ZERO_GR0_EN
    gr_d[0] = 16'h0000;
`endif
  end

  // State registers with asynchronous clear.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wb_ir_q      <= 16'h0000;
      reg_c1_q     <= 16'h0000;
      retire_cnt_q <= '0;
      halted_q     <= 1'b0;
      for (int i = 0; i < 8; i++) gr_q[i] <= 16'h0000;
    end else begin
      wb_ir_q      <= wb_ir_d;
      reg_c1_q     <= reg_c1_d;
      retire_cnt_q <= retire_cnt_d;
      halted_q     <= halted_d;
      for (int i = 0; i < 8; i++) gr_q[i] <= gr_d[i];
    end
  end

  assign wb_ir      = wb_ir_q;
  assign reg_C1     = reg_c1_q;
  assign retire_cnt = retire_cnt_q;
  assign halted     = halted_q;
  assign gr0        = gr_q[0];
  assign gr1        = gr_q[1];
  assign gr2        = gr_q[2];
  assign gr3        = gr_q[3];
  assign gr4        = gr_q[4];
  assign gr5        = gr_q[5];
  assign gr6        = gr_q[6];
  assign gr7        = gr_q[7];

endmodule

// File: tb/tb_wb_regfile.sv
// Directed bench for wb_regfile: per-cycle comparison against a behavioural model
// plus literal spot checks. RETIRE_W is reduced to 4 so the counter wrap is reachable.

module tb_wb_regfile;

  localparam int RW = 4;

  logic          clock = 1'b0;
  logic          reset;
  logic          state;
  logic [15:0]   mem_ir, reg_C, d_datain;
  logic [15:0]   wb_ir, reg_C1;
  logic [15:0]   gr0, gr1, gr2, gr3, gr4, gr5, gr6, gr7;
  logic [RW-1:0] retire_cnt;
  logic          halted;

  int checks = 0;
  int errors = 0;
  bit started = 1'b0;

  // Model state
  logic [15:0]   m_gr [0:7];
  logic [15:0]   m_wb_ir, m_c1;
  int            m_ret;
  bit            m_halt;

  wb_regfile #(.RETIRE_W(RW)) dut (
    .clock(clock), .reset(reset), .state(state), .mem_ir(mem_ir), .reg_C(reg_C),
    .d_datain(d_datain), .wb_ir(wb_ir), .reg_C1(reg_C1),
    .gr0(gr0), .gr1(gr1), .gr2(gr2), .gr3(gr3), .gr4(gr4), .gr5(gr5), .gr6(gr6), .gr7(gr7),
    .retire_cnt(retire_cnt), .halted(halted)
  );

  always #5 clock = ~clock;

  function automatic bit writes_reg(input logic [4:0] op);
    return op inside {5'b00010, 5'b10000, 5'b01000, 5'b01001, 5'b10001, 5'b01010, 5'b01011,
                      5'b10010, 5'b01101, 5'b01110, 5'b01111, 5'b00100, 5'b00110, 5'b00101, 5'b00111};
  endfunction

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: one architectural step per exec edge while not halted.
  always @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 8; i++) m_gr[i] = 16'h0;
      m_wb_ir = 16'h0; m_c1 = 16'h0; m_ret = 0; m_halt = 0;
    end else if (state == 1'b1 && !m_halt) begin
      int dest;
      dest = int'(m_wb_ir[10:8]);
      if (writes_reg(m_wb_ir[15:11])) begin
`ifdef REGFILE_ZERO_GR0_EN
        if (dest != 0) m_gr[dest] = m_c1;
`else
        m_gr[dest] = m_c1;
`endif
      end
      if (m_wb_ir != 16'h0) m_ret = (m_ret + 1) % (1 << RW);
      if (m_wb_ir[15:11] == 5'b00001) m_halt = 1;
      m_wb_ir = mem_ir;
      m_c1 = (mem_ir[15:11] == 5'b00010) ? d_datain : reg_C;
    end
  end

  // Every-cycle comparison of all outputs against the model.
  always @(negedge clock) begin
    if (started) begin
      check("wb_ir", wb_ir, m_wb_ir);
      check("reg_C1", reg_C1, m_c1);
      check("gr0", gr0, m_gr[0]); check("gr1", gr1, m_gr[1]);
      check("gr2", gr2, m_gr[2]); check("gr3", gr3, m_gr[3]);
      check("gr4", gr4, m_gr[4]); check("gr5", gr5, m_gr[5]);
      check("gr6", gr6, m_gr[6]); check("gr7", gr7, m_gr[7]);
      check("retire_cnt", 16'(retire_cnt), 16'(m_ret));
      check("halted", 16'(halted), 16'(m_halt));
    end
  end

  task automatic cyc(input logic [15:0] ir, input logic [15:0] c, input logic [15:0] d, input logic st);
    mem_ir = ir; reg_C = c; d_datain = d; state = st;
    @(negedge clock);
  endtask

  initial begin
    reset = 1'b0; state = 1'b0; mem_ir = 16'h0; reg_C = 16'h0; d_datain = 16'h0;
    @(negedge clock);
    #3 reset = 1'b1;
    @(negedge clock);
    started = 1'b1;
    check("rst_wb_ir", wb_ir, 16'h0000);
    check("rst_gr3", gr3, 16'h0000);
    check("rst_retire", 16'(retire_cnt), 16'h0000);

    // ADD r3 with 0x1234
    cyc(16'h4300, 16'h1234, 16'h0000, 1'b1);
    check("add_wb_ir", wb_ir, 16'h4300);
    check("add_c1", reg_C1, 16'h1234);
    check("add_gr3_notyet", gr3, 16'h0000);
    cyc(16'h0000, 16'h0000, 16'h0000, 1'b1);
    check("add_gr3", gr3, 16'h1234);
    check("add_retire", 16'(retire_cnt), 16'd1);

    // LOAD r5 takes memory data, not reg_C
    cyc(16'h1500, 16'h0007, 16'hBEEF, 1'b1);
    check("load_c1", reg_C1, 16'hBEEF);
    cyc(16'h0000, 16'h0000, 16'h0000, 1'b1);
    check("load_gr5", gr5, 16'hBEEF);

    // STORE r2 then CMP r1: retired, no gr write
    cyc(16'h1A00, 16'hFFFF, 16'h0000, 1'b1);
    cyc(16'h6100, 16'hFFFF, 16'h0000, 1'b1);
    cyc(16'h0000, 16'h0000, 16'h0000, 1'b1);
    cyc(16'h0000, 16'h0000, 16'h0000, 1'b1);
    check("nonwr_gr2", gr2, 16'h0000);
    check("nonwr_gr1", gr1, 16'h0000);
    check("nonwr_retire", 16'(retire_cnt), 16'd4);

    // SUB r6 held in WB while idle
    cyc(16'h5600, 16'h0042, 16'h0000, 1'b1);
    for (int i = 0; i < 3; i++) cyc(16'h0000, 16'h0000, 16'h0000, 1'b0);
    check("idle_gr6", gr6, 16'h0000);
    check("idle_wb_ir", wb_ir, 16'h5600);
    check("idle_retire", 16'(retire_cnt), 16'd4);
    cyc(16'h0000, 16'h0000, 16'h0000, 1'b1);
    check("idle_gr6_commit", gr6, 16'h0042);
    check("idle_retire2", 16'(retire_cnt), 16'd5);

    // ADDI r0
    cyc(16'h4800, 16'h00AA, 16'h0000, 1'b1);
    check("gr0_c1", reg_C1, 16'h00AA);
    cyc(16'h0000, 16'h0000, 16'h0000, 1'b1);
`ifdef REGFILE_ZERO_GR0_EN
    check("gr0_val", gr0, 16'h0000);
`else
    check("gr0_val", gr0, 16'h00AA);
`endif
    check("gr0_retire", 16'(retire_cnt), 16'd6);

    // Back-to-back writes to r4
    cyc(16'h4400, 16'h1111, 16'h0000, 1'b1);
    cyc(16'h4400, 16'h2222, 16'h0000, 1'b1);
    check("b2b_first", gr4, 16'h1111);
    cyc(16'h0000, 16'h0000, 16'h0000, 1'b1);
    check("b2b_gr4", gr4, 16'h2222);
    check("b2b_retire", 16'(retire_cnt), 16'd8);

    // Eight ADD r7 writes wrap the 4-bit counter
    for (int i = 0; i < 8; i++) cyc(16'h4700, 16'(i), 16'h0000, 1'b1);
    cyc(16'h0000, 16'h0000, 16'h0000, 1'b1);
    check("wrap_gr7", gr7, 16'h0007);
    check("wrap_retire", 16'(retire_cnt), 16'd0);

    // HALT followed by ADDI r1
    cyc(16'h0800, 16'h0000, 16'h0000, 1'b1);
    cyc(16'h4900, 16'h5555, 16'h0000, 1'b1);
    check("halt_flag", 16'(halted), 16'd1);
    check("halt_retire", 16'(retire_cnt), 16'd1);
    cyc(16'h4200, 16'h9999, 16'h0000, 1'b1);
    cyc(16'h0000, 16'h0000, 16'h0000, 1'b0);
    cyc(16'h4200, 16'h9999, 16'h0000, 1'b1);
    check("halt_gr1", gr1, 16'h0000);
    check("halt_wb_ir", wb_ir, 16'h4900);
    check("halt_c1", reg_C1, 16'h5555);
    check("halt_retire_frozen", 16'(retire_cnt), 16'd1);

    // Asynchronous reset mid-cycle
    @(posedge clock);
    #2 reset = 1'b0;
    #1;
    check("arst_wb_ir", wb_ir, 16'h0000);
    check("arst_gr5", gr5, 16'h0000);
    check("arst_halted", 16'(halted), 16'd0);
    check("arst_retire", 16'(retire_cnt), 16'd0);
    @(negedge clock);
    #2 reset = 1'b1;
    @(negedge clock);
    cyc(16'h4300, 16'hA5A5, 16'h0000, 1'b1);
    cyc(16'h0000, 16'h0000, 16'h0000, 1'b1);
    check("post_rst_gr3", gr3, 16'hA5A5);

    started = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
